i3c_phy_drv_ctrl: RTL

Parametrised, registered OD/PP driver controller for LANES bus lines (SCL, SDA, …). It sits between the controller/target FSMs and the pad cells, and replaces the combinational OD/PP mux. It adds:
- glitch-free mode transitions
- a timed push-pull-high-to-open-drain handoff (I3C high-keeper handover)
- input synchronisation
- optional drive-high contention detection.

---
 rtl/i3c_phy_drv_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i3c_phy_drv_ctrl.sv
// i3c_phy_drv_ctrl: registered per-lane OD/PP pad driver controller with a
// timed push-pull-high to open-drain handoff, line_i synchroniser and optional
// drive-high contention detection (enabled by I3C_PHY_CONTENTION_DET_EN).
module i3c_phy_drv_ctrl #(
    parameter int unsigned LANES          = 2,
    parameter int unsigned HANDOFF_CYCLES = 2,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LANES-1:0] data_i,
    input  logic [LANES-1:0] pp_en_i,
    input  logic [LANES-1:0] line_i,
    output logic [LANES-1:0] oe_o,
    output logic [LANES-1:0] out_o,
    output logic [LANES-1:0] line_o,
    output logic [LANES-1:0] handoff_o,
    input  logic [LANES-1:0] contention_clr_i,
    output logic [LANES-1:0] contention_o
);

    // A zero-cycle handoff still needs a legal one-bit counter.
    localparam int unsigned CNT_W = (HANDOFF_CYCLES > 0) ? $clog2(HANDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HANDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OD      = 2'd0,
        ST_PP      = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t           state_q [LANES];
    state_t           state_d [LANES];
    logic [CNT_W-1:0] cnt_q   [LANES];
    logic [CNT_W-1:0] cnt_d   [LANES];
    logic [LANES-1:0] oe_d;
    logic [LANES-1:0] out_d;
    logic [LANES-1:0] handoff_d;

    logic [SYNC_STAGES-1:0] sync_q [LANES];

    // Per-lane next-state, handoff counter and next pad encoding.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            oe_d[i]    = 1'b0;
            out_d[i]   = 1'b0;
            handoff_d[i] = 1'b0;

            case (state_q[i])
                ST_OD: begin
                    if (pp_en_i[i]) begin
                        state_d[i] = ST_PP;
                    end
                end
                ST_PP: begin
                    if (!pp_en_i[i]) begin
                        // Only a line currently driven high needs the keeper handover.
                        if (out_o[i] && (HANDOFF_CYCLES > 0)) begin
                            state_d[i] = ST_HANDOFF;
                            cnt_d[i]   = CNT_LOAD;
                        end else begin
                            state_d[i] = ST_OD;
                            cnt_d[i]   = '0;
                        end
                    end
                end
                ST_HANDOFF: begin
                    if (pp_en_i[i]) begin
                        state_d[i] = ST_PP;
                        cnt_d[i]   = '0;
                    end else if (!data_i[i]) begin
                        state_d[i] = ST_OD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] <= CNT_ONE) begin
                        state_d[i] = ST_OD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_OD;
                    cnt_d[i]   = '0;
                end
            endcase

            case (state_d[i])
                ST_PP: begin
                    oe_d[i]  = 1'b1;
                    out_d[i] = data_i[i];
                end
                ST_HANDOFF: begin
                    oe_d[i]      = 1'b1;
                    out_d[i]     = 1'b1;
                    handoff_d[i] = 1'b1;
                end
                default: begin
                    oe_d[i]  = ~data_i[i];
                    out_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Driver state and registered pad outputs; reset releases every lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= ST_OD;
                cnt_q[i]   <= '0;
            end
            oe_o      <= '0;
            out_o     <= '0;
            handoff_o <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            oe_o      <= oe_d;
            out_o     <= out_d;
            handoff_o <= handoff_d;
        end
    end

    // Line synchroniser; resets high to match the pulled-up idle bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_i[i]};
            end
        end
    end

    // Synchronised line value is the last synchroniser flop.
    always_comb begin
        line_o = '0;
        for (int i = 0; i < LANES; i++) begin
            line_o[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

`ifdef I3C_PHY_CONTENTION_DET_EN
    // Age must cover the synchroniser latency plus the output register.
    localparam int unsigned AGE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(SYNC_STAGES + 1);

    logic [AGE_W-1:0] age_q [LANES];
    logic [LANES-1:0] cont_q;

    // Drive-high age and sticky contention flag; a set beats a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                age_q[i] <= '0;
            end
            cont_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (oe_o[i] && out_o[i]) begin
                    age_q[i] <= (age_q[i] == AGE_MAX) ? age_q[i] : (age_q[i] + AGE_ONE);
                end else begin
                    age_q[i] <= '0;
                end
                if ((age_q[i] >= AGE_THR) && !line_o[i]) begin
                    cont_q[i] <= 1'b1;
                end else if (contention_clr_i[i]) begin
                    cont_q[i] <= 1'b0;
                end
            end
        end
    end

    assign contention_o = cont_q;
`else
    logic unused_contention_clr;
    assign unused_contention_clr = ^contention_clr_i;
    assign contention_o = '0;
`endif

endmodule
